// File: rtl/exe_maint_responder.sv
// Serialises execute-stage TLB and cache maintenance requests onto the TLB and cache ports,
// one op at a time, returning a one-cycle done pulse (suppressed if the stage was flushed).
module exe_maint_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_reset,

  input  logic        tlbcheck_do,
  input  logic [31:0] tlbcheck_address,
  input  logic        tlbcheck_rw,
  output logic        tlbcheck_done,
  output logic        tlbcheck_page_fault,

  input  logic        tlbflushsingle_do,
  input  logic [31:0] tlbflushsingle_address,
  output logic        tlbflushsingle_done,

  input  logic        invdcode_do,
  input  logic        invddata_do,
  input  logic        wbinvddata_do,
  output logic        invdcode_done,
  output logic        invddata_done,
  output logic        wbinvddata_done,

  output logic        tlb_req,
  output logic [1:0]  tlb_op,
  output logic [31:0] tlb_address,
  input  logic        tlb_ack,
  input  logic        tlb_fault,

  output logic        cache_req,
  output logic [1:0]  cache_op,
  input  logic        cache_ack,

  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StTlbWait,
    StCacheWait,
    StDone,
    StGap
  } state_e;

  typedef enum logic [2:0] {
    ReqNone,
    ReqCheck,
    ReqFlush,
    ReqWbinvd,
    ReqInvdData,
    ReqInvdCode
  } req_e;

  state_e      state_q, state_d;
  req_e        req_q, req_d;
  logic [1:0]  tlb_op_q, tlb_op_d;
  logic [1:0]  cache_op_q, cache_op_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;
  logic        abort_q, abort_d;
  logic        done_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= ReqNone;
      tlb_op_q   <= 2'b00;
      cache_op_q <= 2'b00;
      addr_q     <= 32'h0;
      fault_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      tlb_op_q   <= tlb_op_d;
      cache_op_q <= cache_op_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tlb_op_d   = tlb_op_q;
    cache_op_d = cache_op_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    abort_d    = abort_q;

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        // Fixed priority; losers keep their do high and are re-arbitrated after GAP.
        if (!exe_reset) begin
          if (tlbcheck_do) begin
            req_d    = ReqCheck;
            tlb_op_d = {1'b0, tlbcheck_rw};
            addr_d   = tlbcheck_address;
            fault_d  = 1'b0;
            state_d  = StTlbWait;
          end else if (tlbflushsingle_do) begin
            req_d    = ReqFlush;
            tlb_op_d = 2'b10;
            addr_d   = tlbflushsingle_address;
            fault_d  = 1'b0;
            state_d  = StTlbWait;
          end else if (wbinvddata_do) begin
            req_d      = ReqWbinvd;
            cache_op_d = 2'b10;
            addr_d     = 32'h0;
            fault_d    = 1'b0;
            state_d    = StCacheWait;
          end else if (invddata_do) begin
            req_d      = ReqInvdData;
            cache_op_d = 2'b01;
            addr_d     = 32'h0;
            fault_d    = 1'b0;
            state_d    = StCacheWait;
          end else if (invdcode_do) begin
            req_d      = ReqInvdCode;
            cache_op_d = 2'b00;
            addr_d     = 32'h0;
            fault_d    = 1'b0;
            state_d    = StCacheWait;
          end
        end
      end
      StTlbWait: begin
        // A flush cannot cancel the downstream op; it only suppresses the done pulse.
        if (exe_reset) abort_d = 1'b1;
        if (tlb_ack) begin
          fault_d = tlb_fault & (req_q == ReqCheck);
          state_d = StDone;
        end
      end
      StCacheWait: begin
        if (exe_reset) abort_d = 1'b1;
        if (cache_ack) begin
          fault_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        abort_d = 1'b0;
        state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign done_en = (state_q == StDone) & ~abort_q & ~exe_reset;

  assign tlbcheck_done       = done_en & (req_q == ReqCheck);
  assign tlbflushsingle_done = done_en & (req_q == ReqFlush);
  assign wbinvddata_done     = done_en & (req_q == ReqWbinvd);
  assign invddata_done       = done_en & (req_q == ReqInvdData);
  assign invdcode_done       = done_en & (req_q == ReqInvdCode);
  assign tlbcheck_page_fault = tlbcheck_done & fault_q;

  assign tlb_req     = (state_q == StTlbWait);
  assign cache_req   = (state_q == StCacheWait);
  assign tlb_op      = tlb_op_q;
  assign tlb_address = addr_q;
  assign cache_op    = cache_op_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_exe_maint_responder.sv
// Bench for exe_maint_responder: vector table of single ops, hand sequences for
// arbitration, flush-abort, stray acks and mid-op reset; done pulses scored from a queue.
module tb_exe_maint_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_reset;
  logic        tlbcheck_do, tlbcheck_rw, tlbcheck_done, tlbcheck_page_fault;
  logic [31:0] tlbcheck_address;
  logic        tlbflushsingle_do, tlbflushsingle_done;
  logic [31:0] tlbflushsingle_address;
  logic        invdcode_do, invddata_do, wbinvddata_do;
  logic        invdcode_done, invddata_done, wbinvddata_done;
  logic        tlb_req, tlb_ack, tlb_fault;
  logic [1:0]  tlb_op;
  logic [31:0] tlb_address;
  logic        cache_req, cache_ack;
  logic [1:0]  cache_op;
  logic        busy;

  always #5 clk = ~clk;

  exe_maint_responder dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .exe_reset              (exe_reset),
    .tlbcheck_do            (tlbcheck_do),
    .tlbcheck_address       (tlbcheck_address),
    .tlbcheck_rw            (tlbcheck_rw),
    .tlbcheck_done          (tlbcheck_done),
    .tlbcheck_page_fault    (tlbcheck_page_fault),
    .tlbflushsingle_do      (tlbflushsingle_do),
    .tlbflushsingle_address (tlbflushsingle_address),
    .tlbflushsingle_done    (tlbflushsingle_done),
    .invdcode_do            (invdcode_do),
    .invddata_do            (invddata_do),
    .wbinvddata_do          (wbinvddata_do),
    .invdcode_done          (invdcode_done),
    .invddata_done          (invddata_done),
    .wbinvddata_done        (wbinvddata_done),
    .tlb_req                (tlb_req),
    .tlb_op                 (tlb_op),
    .tlb_address            (tlb_address),
    .tlb_ack                (tlb_ack),
    .tlb_fault              (tlb_fault),
    .cache_req              (cache_req),
    .cache_op               (cache_op),
    .cache_ack              (cache_ack),
    .busy                   (busy)
  );

  // Bit order for do/done vectors: {check, flush, wbinvd, invddata, invdcode}
  logic [4:0] done_vec;
  assign done_vec = {tlbcheck_done, tlbflushsingle_done, wbinvddata_done, invddata_done,
                     invdcode_done};

  typedef struct {
    logic [4:0]  dos;
    logic [31:0] chk_addr;
    logic        rw;
    logic [31:0] fl_addr;
    int          lat;
    logic        fault_in;
    logic        is_tlb;
    logic [1:0]  exp_op;
    logic [31:0] exp_addr;
    logic        exp_pf;
  } vec_t;

  typedef struct {
    logic [4:0] done;
    logic       pf;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic set_do(input logic [4:0] d);
    {tlbcheck_do, tlbflushsingle_do, wbinvddata_do, invddata_do, invdcode_do} = d;
  endtask

  // Scoreboard and always-on invariants, sampled mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    if (done_vec != 5'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done_vec), 32'h0);
      end else begin
        e = sb.pop_front();
        check("sb_done", 32'(done_vec), 32'(e.done));
        check("sb_page_fault", 32'(tlbcheck_page_fault), 32'(e.pf));
      end
    end
    if ($countones(done_vec) > 1) check("done_onehot", 32'($countones(done_vec)), 32'h1);
    if (tlb_req && cache_req) check("req_exclusive", 32'h1, 32'h0);
    if (tlbcheck_page_fault && !tlbcheck_done) check("pf_qualified", 32'h1, 32'h0);
  end

  // Serve one op: waits for req, checks op/address, acks after lat cycles, checks DONE and GAP.
  // exe_at: wait-cycle index to pulse exe_reset, 100 = pulse in the DONE cycle, -1 = none.
  task automatic serve(input string tag, input logic is_tlb, input logic [1:0] op,
                       input logic [31:0] addr, input int wait_n, input int lat,
                       input logic fault_in, input int exe_at, input logic drop_early,
                       input logic [4:0] exp_done);
    int waited;
    @(negedge clk);
    waited = 1;
    while (!(tlb_req || cache_req) && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_req_latency"}, 32'(waited), 32'(wait_n));
    if (!(tlb_req || cache_req)) return;
    check({tag, "_tlb_req"}, 32'(tlb_req), 32'(is_tlb));
    check({tag, "_cache_req"}, 32'(cache_req), 32'(!is_tlb));
    if (is_tlb) begin
      check({tag, "_tlb_op"}, 32'(tlb_op), 32'(op));
      check({tag, "_tlb_address"}, tlb_address, addr);
    end else begin
      check({tag, "_cache_op"}, 32'(cache_op), 32'(op));
    end
    if (drop_early) set_do(5'b0);
    for (int j = 0; j < lat; j++) begin
      exe_reset = (j == exe_at);
      @(negedge clk);
    end
    exe_reset = 1'b0;
    check({tag, "_req_held"}, 32'(is_tlb ? tlb_req : cache_req), 32'h1);
    if (is_tlb) check({tag, "_tlb_op_stable"}, 32'(tlb_op), 32'(op));
    tlb_ack   = is_tlb;
    cache_ack = !is_tlb;
    tlb_fault = fault_in;
    @(posedge clk);
    #1;
    tlb_ack   = 1'b0;
    cache_ack = 1'b0;
    tlb_fault = 1'b0;
    exe_reset = (exe_at == 100);
    @(negedge clk);
    check({tag, "_done"}, 32'(done_vec), 32'(exp_done));
    check({tag, "_req_drop"}, 32'(tlb_req | cache_req), 32'h0);
    check({tag, "_busy_done"}, 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    exe_reset = 1'b0;
    @(negedge clk);
    check({tag, "_gap_busy"}, 32'(busy), 32'h1);
    check({tag, "_gap_quiet"}, 32'({done_vec, tlb_req, cache_req}), 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{dos: 5'b10000, chk_addr: 32'h1234_5000, rw: 1'b0, fl_addr: 32'h0, lat: 0,
                fault_in: 1'b1, is_tlb: 1'b1, exp_op: 2'b00, exp_addr: 32'h1234_5000,
                exp_pf: 1'b1};
    vecs[1] = '{dos: 5'b10000, chk_addr: 32'h0040_1000, rw: 1'b1, fl_addr: 32'h0, lat: 2,
                fault_in: 1'b1, is_tlb: 1'b1, exp_op: 2'b01, exp_addr: 32'h0040_1000,
                exp_pf: 1'b1};
    vecs[2] = '{dos: 5'b01000, chk_addr: 32'h0, rw: 1'b0, fl_addr: 32'h8000_0000, lat: 1,
                fault_in: 1'b1, is_tlb: 1'b1, exp_op: 2'b10, exp_addr: 32'h8000_0000,
                exp_pf: 1'b0};
    vecs[3] = '{dos: 5'b00100, chk_addr: 32'hdead_0000, rw: 1'b0, fl_addr: 32'h0, lat: 3,
                fault_in: 1'b0, is_tlb: 1'b0, exp_op: 2'b10, exp_addr: 32'h0, exp_pf: 1'b0};
    vecs[4] = '{dos: 5'b00010, chk_addr: 32'h0, rw: 1'b0, fl_addr: 32'h0, lat: 0,
                fault_in: 1'b0, is_tlb: 1'b0, exp_op: 2'b01, exp_addr: 32'h0, exp_pf: 1'b0};
    vecs[5] = '{dos: 5'b00001, chk_addr: 32'h0, rw: 1'b0, fl_addr: 32'h0, lat: 1,
                fault_in: 1'b0, is_tlb: 1'b0, exp_op: 2'b00, exp_addr: 32'h0, exp_pf: 1'b0};
    vecs[6] = '{dos: 5'b10000, chk_addr: 32'hffff_f000, rw: 1'b1, fl_addr: 32'h0, lat: 4,
                fault_in: 1'b0, is_tlb: 1'b1, exp_op: 2'b01, exp_addr: 32'hffff_f000,
                exp_pf: 1'b0};

    rst_n = 1'b0;
    exe_reset = 1'b0;
    set_do(5'b0);
    tlbcheck_address = 32'h0;
    tlbcheck_rw = 1'b0;
    tlbflushsingle_address = 32'h0;
    tlb_ack = 1'b0;
    tlb_fault = 1'b0;
    cache_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_reqs", 32'({tlb_req, cache_req}), 32'h0);
    check("rst_done", 32'({done_vec, tlbcheck_page_fault}), 32'h0);
    check("rst_ops", 32'({tlb_op, cache_op}), 32'h0);
    check("rst_address", tlb_address, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      tlbcheck_address       = vecs[i].chk_addr;
      tlbcheck_rw            = vecs[i].rw;
      tlbflushsingle_address = vecs[i].fl_addr;
      sb.push_back('{done: vecs[i].dos, pf: vecs[i].exp_pf});
      set_do(vecs[i].dos);
      serve($sformatf("vec%0d", i), vecs[i].is_tlb, vecs[i].exp_op, vecs[i].exp_addr, 1,
            vecs[i].lat, vecs[i].fault_in, -1, 1'b0, vecs[i].dos);
      set_do(5'b0);
      @(negedge clk);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'h0);
    end

    // Three simultaneous requests served in priority order with a GAP between ops.
    tlbcheck_address = 32'h0000_2000;
    tlbcheck_rw = 1'b0;
    tlbflushsingle_address = 32'h8000_0000;
    sb.push_back('{done: 5'b10000, pf: 1'b0});
    sb.push_back('{done: 5'b01000, pf: 1'b0});
    sb.push_back('{done: 5'b00001, pf: 1'b0});
    set_do(5'b11001);
    serve("arb_chk", 1'b1, 2'b00, 32'h0000_2000, 1, 1, 1'b0, -1, 1'b0, 5'b10000);
    tlbcheck_do = 1'b0;
    serve("arb_flush", 1'b1, 2'b10, 32'h8000_0000, 2, 0, 1'b0, -1, 1'b0, 5'b01000);
    tlbflushsingle_do = 1'b0;
    serve("arb_invdc", 1'b0, 2'b00, 32'h0, 2, 2, 1'b0, -1, 1'b0, 5'b00001);
    invdcode_do = 1'b0;
    @(negedge clk);
    check("arb_idle", 32'(busy), 32'h0);

    // Flush during the wait: op completes, done suppressed, idle three cycles after ack.
    set_do(5'b00100);
    serve("abort_wait", 1'b0, 2'b10, 32'h0, 1, 5, 1'b0, 1, 1'b0, 5'b00000);
    set_do(5'b0);
    @(negedge clk);
    check("abort_wait_idle", 32'(busy), 32'h0);

    // Flush only in the DONE cycle also suppresses done.
    tlbcheck_address = 32'h0000_3000;
    set_do(5'b10000);
    serve("abort_done", 1'b1, 2'b00, 32'h0000_3000, 1, 1, 1'b1, 100, 1'b0, 5'b00000);
    set_do(5'b0);
    @(negedge clk);

    // Stray acks in IDLE are ignored; the op waits for its own ack.
    for (int j = 0; j < 2; j++) begin
      tlb_ack = 1'b1;
      cache_ack = 1'b1;
      @(negedge clk);
      check($sformatf("stray_ack%0d_busy", j), 32'(busy), 32'h0);
    end
    tlb_ack = 1'b0;
    cache_ack = 1'b0;
    sb.push_back('{done: 5'b00010, pf: 1'b0});
    set_do(5'b00010);
    serve("stray", 1'b0, 2'b01, 32'h0, 1, 2, 1'b0, -1, 1'b0, 5'b00010);
    set_do(5'b0);
    @(negedge clk);

    // do withdrawn before ack still completes.
    tlbcheck_address = 32'h0abc_d000;
    tlbcheck_rw = 1'b1;
    sb.push_back('{done: 5'b10000, pf: 1'b0});
    set_do(5'b10000);
    serve("early_drop", 1'b1, 2'b01, 32'h0abc_d000, 1, 2, 1'b0, -1, 1'b1, 5'b10000);
    @(negedge clk);

    // exe_reset in IDLE blocks acceptance.
    exe_reset = 1'b1;
    tlbflushsingle_address = 32'h0000_7000;
    set_do(5'b01000);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("idle_flush%0d_busy", j), 32'(busy), 32'h0);
    end
    sb.push_back('{done: 5'b01000, pf: 1'b0});
    exe_reset = 1'b0;
    serve("post_flush", 1'b1, 2'b10, 32'h0000_7000, 1, 0, 1'b0, -1, 1'b0, 5'b01000);
    set_do(5'b0);
    @(negedge clk);

    // Reset while tlb_req is high, then a late ack.
    tlbcheck_address = 32'h0055_5000;
    tlbcheck_rw = 1'b1;
    set_do(5'b10000);
    @(negedge clk);
    check("mid_rst_req", 32'(tlb_req), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_reqs", 32'({tlb_req, cache_req, busy}), 32'h0);
    check("mid_rst_done", 32'({done_vec, tlbcheck_page_fault}), 32'h0);
    check("mid_rst_op", 32'({tlb_op, cache_op}), 32'h0);
    check("mid_rst_address", tlb_address, 32'h0);
    rst_n = 1'b1;
    set_do(5'b0);
    tlb_ack = 1'b1;
    tlb_fault = 1'b1;
    @(negedge clk);
    tlb_ack = 1'b0;
    tlb_fault = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("late_ack%0d", j), 32'({done_vec, busy}), 32'h0);
    end

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exe_maint_responder.md
EXE_MAINT_RESPONDER -- requirements
Module: exe_maint_responder

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low; all state changes on posedge clk.
REQ-002 SHALL have port: exe_reset  in  1  execute-stage flush, abort qualifier.
REQ-003 SHALL have ports: tlbcheck_do  in  1  level request; tlbcheck_address  in  32  linear address; tlbcheck_rw  in  1  1=write check.
REQ-004 SHALL have ports: tlbcheck_done  out  1  one-cycle completion pulse; tlbcheck_page_fault  out  1  fault result, valid only with tlbcheck_done.
REQ-005 SHALL have ports: tlbflushsingle_do  in  1; tlbflushsingle_address  in  32; tlbflushsingle_done  out  1.
REQ-006 SHALL have ports: invdcode_do, invddata_do, wbinvddata_do  in  1 each; invdcode_done, invddata_done, wbinvddata_done  out  1 each.
REQ-007 SHALL have ports: tlb_req  out  1; tlb_op  out  2  (00 check-read, 01 check-write, 10 flush-single); tlb_address  out  32; tlb_ack  in  1  one-cycle; tlb_fault  in  1  valid with tlb_ack.
REQ-008 SHALL have ports: cache_req  out  1; cache_op  out  2  (00 invd-code, 01 invd-data, 10 wbinvd-data); cache_ack  in  1  one-cycle.
REQ-009 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, TLB_WAIT, CACHE_WAIT, DONE, GAP.
REQ-011 In IDLE with exe_reset=0, SHALL select one active request by fixed priority: tlbcheck > tlbflushsingle > wbinvddata > invddata > invdcode.
REQ-012 On selection, SHALL latch op code, address (tlbcheck_address or tlbflushsingle_address; 0 for cache ops) and requester ID, then go to TLB_WAIT or CACHE_WAIT.
REQ-013 In IDLE with exe_reset=1, SHALL accept no request and stay in IDLE.
REQ-014 In TLB_WAIT/CACHE_WAIT, SHALL hold tlb_req/cache_req=1 with stable tlb_op/cache_op/tlb_address until the matching ack.
REQ-015 The ack cycle SHALL be the last cycle req is high; on ack SHALL latch tlb_fault (0 for non-check ops) and go to DONE.
REQ-016 SHALL ignore an ack arriving when the matching req is low.
REQ-017 In DONE, SHALL drive the done output of the latched requester high for exactly one cycle, then go to GAP.
REQ-018 tlbcheck_page_fault SHALL equal the latched fault during tlbcheck_done and be 0 otherwise.
REQ-019 GAP SHALL last exactly one cycle with no request sampled, then go to IDLE; this absorbs the initiator dropping its do.
REQ-020 Latency: do sampled in IDLE at cycle 0, req at cycle 1, ack at cycle k>=1, done at cycle k+1, IDLE at k+3; minimum do-to-done is 2 cycles.
REQ-021 If exe_reset=1 in any cycle of TLB_WAIT/CACHE_WAIT, SHALL set an abort flag and keep req high until ack (downstream op is not cancellable).
REQ-022 If the abort flag is set, or exe_reset=1 in the DONE cycle, SHALL suppress all done outputs in DONE; the abort flag SHALL clear on entering GAP.
REQ-023 SHALL complete an accepted op and pulse done even if its do deasserts before ack while exe_reset=0.
REQ-024 Simultaneous do assertions: only the winner SHALL be served; losers remain pending and are re-arbitrated in IDLE after GAP.
REQ-025 At most one done output SHALL be high in any cycle; tlb_req and cache_req SHALL never be high together.

Reset
REQ-026 With rst_n=0 at a clock edge: state=IDLE; all done outputs, tlbcheck_page_fault, tlb_req, cache_req, busy=0; tlb_op, cache_op, tlb_address, latched fault, requester ID, abort flag=0.
REQ-027 Reset mid-operation SHALL drop req the following cycle without waiting for ack; any later stray ack SHALL be ignored per REQ-016.

Verification
REQ-028 tlbcheck_do=1, address=0x0040_1000, rw=1; tlb_ack=1, tlb_fault=1 two cycles after tlb_req rises -> tlb_op=01, tlb_address=0x0040_1000, tlbcheck_done and tlbcheck_page_fault=1 for one cycle, one cycle after ack.
REQ-029 tlbcheck_do, tlbflushsingle_do (0x8000_0000) and invdcode_do all rise in the same cycle -> served in order check, flush (tlb_op=10), invd-code (cache_op=00), each done pulsed once, GAP cycle between ops.
REQ-030 wbinvddata_do=1, exe_reset pulsed for one cycle while cache_req=1, cache_ack after 5 cycles -> cache_req held until ack, wbinvddata_done never asserted, busy=0 three cycles after ack.
REQ-031 invddata_do=1, tlb_ack and cache_ack pulsed in IDLE before acceptance -> acks ignored; op still waits for its own cache_ack, then invddata_done pulses once.
REQ-032 rst_n=0 asserted while tlb_req=1 -> next cycle all outputs 0, state IDLE; a tlb_ack arriving after reset produces no done pulse.
